dm_port_arbiter: RTL and testbench
==================================

Name: dm_port_arbiter

Overview:
- Shares the single-port data memory between two requesters:
  - the core MEM stage (primary);
  - a UART-driven debug/loader master (secondary).
- Sits between Core's MEM stage and the dm instance.
- Stalls the pipeline when the debug master is granted a cycle.
- Routes the one-cycle-latency read data back to the requester that issued the read.

Parameters:
ADDR_W, 32, data-memory byte-address width
DATA_W, 32, data word width
MAX_WAIT, 8, cycles a pending debug request may be starved by the core before it is forced through
LOCK_MAX, 16, maximum consecutive locked debug grants before the core is given one slot

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
core_req  in  1  MEM-stage access request
core_we  in  1  1 = store, 0 = load
core_addr  in  ADDR_W  byte address
core_wdata  in  DATA_W  store data
core_fn3  in  3  funct3 size/sign code
core_stall  out  1  freeze pipeline; request not taken this cycle
core_rvalid  out  1  core load data valid
core_rdata  out  DATA_W  core load data
dbg_req  in  1  debug access request
dbg_we  in  1  debug write
dbg_addr  in  ADDR_W  debug address
dbg_wdata  in  DATA_W  debug write data
dbg_fn3  in  3  debug funct3
dbg_lock  in  1  hold ownership across consecutive beats (loader bursts)
dbg_gnt  out  1  debug request accepted this cycle
dbg_rvalid  out  1  debug read data valid
dbg_rdata  out  DATA_W  debug read data
dm_addr  out  ADDR_W  to memory
dm_wen  out  1  to memory
dm_wdata  out  DATA_W  to memory
dm_fn3  out  3  to memory
dm_rdata  in  DATA_W  memory read data, valid one cycle after address

Behaviour:
- Reset (async, rst=1):
  - owner=OWN_NONE, resp_owner=OWN_NONE, wait_cnt=0, lock_cnt=0.
  - All outputs 0.
  - A read in flight is discarded; no rvalid is issued after reset deasserts.
- Grant decision each cycle (combinational from registered state; priority order):
  1. lock_active (previous grant=DBG, dbg_lock=1, lock_cnt<LOCK_MAX) and dbg_req -> DBG.
  2. dbg_req and wait_cnt==MAX_WAIT -> DBG.
  3. core_req -> CORE.
  4. dbg_req -> DBG.
  5. Otherwise none.
- Outputs of the decision:
  - core_stall = core_req & ~core_grant.
  - dbg_gnt = dbg_grant.
  - dm_* driven by the granted requester's signals.
  - With no grant: dm_wen=0 and other dm_* are don't-care (driven 0).
- wait_cnt:
  - +1, saturating at MAX_WAIT, when dbg_req=1 and not granted.
  - Cleared when dbg is granted or dbg_req=0.
- lock_cnt:
  - +1 on each DBG grant with dbg_lock=1.
  - Cleared on any non-DBG cycle or when dbg_lock=0.
  - At LOCK_MAX with core_req=1, the next slot goes to CORE; lock_cnt then clears.
- Read return:
  - A granted read (we=0) sets resp_owner=<grantee> for exactly the next cycle.
  - That cycle: the matching rvalid=1 and its rdata=dm_rdata. The other rdata holds 0.
  - Writes produce no rvalid.
- Back-to-back:
  - A new grant may occur in the same cycle as a previous read's rvalid (full throughput, one access per cycle).
- Boundary cases:
  - dbg_req dropping during a lock ends the lock immediately.
  - Simultaneous core_req and dbg_req with wait_cnt<MAX_WAIT and no lock -> CORE.
  - MAX_WAIT=0 means debug always wins a tie.
  - Addresses and fn3 are passed through unchanged; alignment checking is the memory's job.

Decomposition:
- Package dm_arb_pkg:
  - owner_e enum {OWN_NONE, OWN_CORE, OWN_DBG};
  - mem_req_t struct {we, addr, wdata, fn3}.
- fn3 constants stay in definitions.svh.
- One sub-module: sat_counter (parameterised width/limit, inc/clr, at_max flag).
  - Instantiated twice: wait_cnt and lock_cnt.

Test Plan:
- Core-only load at 0x10 with mem[4]=0xDEADBEEF:
  - core_stall=0;
  - next cycle core_rvalid=1, core_rdata=0xDEADBEEF;
  - dbg_rvalid=0.
- Core and debug both requesting continuously, MAX_WAIT=8:
  - core granted 8 cycles;
  - 9th cycle dbg_gnt=1, core_stall=1;
  - wait_cnt returns to 0.
- Debug locked burst of 20 writes while core_req=1, LOCK_MAX=16:
  - 16 dbg grants;
  - then one core grant (core_stall=0);
  - then debug resumes.
- Debug read at 0x20 then core write to 0x20 (0x12345678) on the following cycle:
  - dbg_rvalid carries the old value;
  - subsequent core read returns 0x12345678.
- rst pulsed in the cycle after a granted core read:
  - core_rvalid stays 0;
  - all counters read 0;
  - next request is granted normally.
- Idle (no requests) for 10 cycles:
  - dm_wen=0 throughout;
  - no rvalid;
  - no stall.

Source files
------------

// File: rtl/dm_arb_pkg.sv
// dm_arb_pkg: shared types and helpers for the data-memory port arbiter.
//   owner_e   - which requester owns a memory slot (or none)
//   mem_req_t - one memory access as seen by the single dm port
//   cnt_width - register width needed to count from 0 up to a limit
package dm_arb_pkg;

   // Struct fields are sized for the widest supported configuration.
   // Narrower ports are zero-extended into the struct and sliced back out.
   localparam int REQ_ADDR_W = 32;
   localparam int REQ_DATA_W = 32;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CORE = 2'd1,
      OWN_DBG  = 2'd2
   } owner_e;

   typedef struct packed {
      logic                  we;
      logic [REQ_ADDR_W-1:0] addr;
      logic [REQ_DATA_W-1:0] wdata;
      logic [2:0]            fn3;
   } mem_req_t;

   // A limit of 0 still needs a 1-bit register.
   function automatic int cnt_width(input int limit);
      return (limit < 1) ? 1 : $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that saturates at LIMIT.
//   clk, rst - clock, asynchronous active-high reset
//   inc      - count up by one (ignored once at LIMIT)
//   clr      - return to zero; wins over inc
//   at_max   - count has reached LIMIT
module sat_counter #(
   parameter int W     = 4,
   parameter int LIMIT = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic clr,
   output logic at_max
);

   logic [W-1:0] count;

   assign at_max = (count == W'(LIMIT));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                count <= '0;
      else if (clr)           count <= '0;
      else if (inc && !at_max) count <= count + W'(1);
   end

endmodule

// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: shares the single-port data memory between the core MEM
// stage (primary) and the UART debug/loader master (secondary).
//   core_*     - MEM-stage request; core_stall freezes the pipeline when the
//                core is not granted, core_rvalid/core_rdata return loads
//   dbg_*      - debug request; dbg_gnt accepts a beat, dbg_lock holds
//                ownership across a burst, dbg_rvalid/dbg_rdata return reads
//   dm_*       - memory port; dm_rdata is valid one cycle after the address
// The grant is combinational from the current requests and registered state,
// so one access per cycle is sustained with reads overlapping the next grant.
module dm_port_arbiter
   import dm_arb_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 8,
   parameter int LOCK_MAX = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              core_req,
   input  logic              core_we,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic [DATA_W-1:0] core_wdata,
   input  logic [2:0]        core_fn3,
   output logic              core_stall,
   output logic              core_rvalid,
   output logic [DATA_W-1:0] core_rdata,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   input  logic [2:0]        dbg_fn3,
   input  logic              dbg_lock,
   output logic              dbg_gnt,
   output logic              dbg_rvalid,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic [ADDR_W-1:0] dm_addr,
   output logic              dm_wen,
   output logic [DATA_W-1:0] dm_wdata,
   output logic [2:0]        dm_fn3,
   input  logic [DATA_W-1:0] dm_rdata
);

   localparam int WAIT_W = cnt_width(MAX_WAIT);
   localparam int LOCK_W = cnt_width(LOCK_MAX);

   owner_e   owner;       // grantee of the previous cycle
   owner_e   resp_owner;  // who receives dm_rdata this cycle
   owner_e   grant;
   mem_req_t core_mr, dbg_mr, sel_mr;
   logic     core_grant, dbg_grant;
   logic     wait_at_max, lock_at_max, lock_active;

   assign core_mr = '{we: core_we, addr: REQ_ADDR_W'(core_addr),
                      wdata: REQ_DATA_W'(core_wdata), fn3: core_fn3};
   assign dbg_mr  = '{we: dbg_we, addr: REQ_ADDR_W'(dbg_addr),
                      wdata: REQ_DATA_W'(dbg_wdata), fn3: dbg_fn3};

   // Lock only extends a burst that already owns the port; the count cap
   // hands the core one slot after LOCK_MAX locked beats.
   assign lock_active = (owner == OWN_DBG) && dbg_lock && !lock_at_max;

   always_comb begin
      grant = OWN_NONE;
      if (rst)                                       grant = OWN_NONE;
      else if (dbg_req && (lock_active || wait_at_max)) grant = OWN_DBG;
      else if (core_req)                             grant = OWN_CORE;
      else if (dbg_req)                              grant = OWN_DBG;
   end

   assign core_grant = (grant == OWN_CORE);
   assign dbg_grant  = (grant == OWN_DBG);

   always_comb begin
      sel_mr = '0;
      if (core_grant)     sel_mr = core_mr;
      else if (dbg_grant) sel_mr = dbg_mr;
   end

   // Outputs are forced low while reset is held.
   assign core_stall = core_req && !core_grant && !rst;
   assign dbg_gnt    = dbg_grant;
   assign dm_addr    = sel_mr.addr[ADDR_W-1:0];
   assign dm_wen     = sel_mr.we;
   assign dm_wdata   = sel_mr.wdata[DATA_W-1:0];
   assign dm_fn3     = sel_mr.fn3;

   // Starvation counter for a pending debug request.
   sat_counter #(.W(WAIT_W), .LIMIT(MAX_WAIT)) u_wait (
      .clk    (clk),
      .rst    (rst),
      .inc    (dbg_req && !dbg_grant),
      .clr    (dbg_grant || !dbg_req),
      .at_max (wait_at_max)
   );

   // Consecutive locked debug grants; any other cycle ends the run.
   sat_counter #(.W(LOCK_W), .LIMIT(LOCK_MAX)) u_lock (
      .clk    (clk),
      .rst    (rst),
      .inc    (dbg_grant && dbg_lock),
      .clr    (!dbg_grant || !dbg_lock),
      .at_max (lock_at_max)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner      <= OWN_NONE;
         resp_owner <= OWN_NONE;
      end else begin
         owner      <= grant;
         resp_owner <= (grant != OWN_NONE && !sel_mr.we) ? grant : OWN_NONE;
      end
   end

   assign core_rvalid = (resp_owner == OWN_CORE);
   assign dbg_rvalid  = (resp_owner == OWN_DBG);
   assign core_rdata  = core_rvalid ? dm_rdata : '0;
   assign dbg_rdata   = dbg_rvalid  ? dm_rdata : '0;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// tb_dm_port_arbiter: directed bench for dm_port_arbiter with a one-cycle
// latency word memory model behind the dm port. A second instance with
// MAX_WAIT=0 shares the inputs to show debug winning every tie.
module tb_dm_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        core_req, core_we;
   logic [31:0] core_addr, core_wdata;
   logic [2:0]  core_fn3;
   logic        core_stall, core_rvalid;
   logic [31:0] core_rdata;
   logic        dbg_req, dbg_we, dbg_lock;
   logic [31:0] dbg_addr, dbg_wdata;
   logic [2:0]  dbg_fn3;
   logic        dbg_gnt, dbg_rvalid;
   logic [31:0] dbg_rdata;
   logic [31:0] dm_addr, dm_wdata, mem_rdata;
   logic        dm_wen;
   logic [2:0]  dm_fn3;

   logic        m0_core_stall, m0_core_rvalid, m0_dbg_gnt, m0_dbg_rvalid, m0_dm_wen;
   logic [31:0] m0_core_rdata, m0_dbg_rdata, m0_dm_addr, m0_dm_wdata;
   logic [2:0]  m0_dm_fn3;

   logic [31:0] mem [0:255];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (dm_wen) mem[dm_addr[9:2]] <= dm_wdata;
      mem_rdata <= mem[dm_addr[9:2]];
   end

   dm_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(8), .LOCK_MAX(16)) dut (
      .clk(clk), .rst(rst),
      .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
      .core_wdata(core_wdata), .core_fn3(core_fn3), .core_stall(core_stall),
      .core_rvalid(core_rvalid), .core_rdata(core_rdata),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
      .dbg_wdata(dbg_wdata), .dbg_fn3(dbg_fn3), .dbg_lock(dbg_lock),
      .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
      .dm_addr(dm_addr), .dm_wen(dm_wen), .dm_wdata(dm_wdata), .dm_fn3(dm_fn3),
      .dm_rdata(mem_rdata)
   );

   dm_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(0), .LOCK_MAX(16)) dut_mw0 (
      .clk(clk), .rst(rst),
      .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
      .core_wdata(core_wdata), .core_fn3(core_fn3), .core_stall(m0_core_stall),
      .core_rvalid(m0_core_rvalid), .core_rdata(m0_core_rdata),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
      .dbg_wdata(dbg_wdata), .dbg_fn3(dbg_fn3), .dbg_lock(dbg_lock),
      .dbg_gnt(m0_dbg_gnt), .dbg_rvalid(m0_dbg_rvalid), .dbg_rdata(m0_dbg_rdata),
      .dm_addr(m0_dm_addr), .dm_wen(m0_dm_wen), .dm_wdata(m0_dm_wdata), .dm_fn3(m0_dm_fn3),
      .dm_rdata(mem_rdata)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are sampled
   // on the falling edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_core(input logic req, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata);
      core_req = req; core_we = we; core_addr = addr; core_wdata = wdata;
   endtask

   task automatic set_dbg(input logic req, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic lock);
      dbg_req = req; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata; dbg_lock = lock;
   endtask

   bit trace_d [0:63];
   bit trace_s [0:63];

   initial begin
      int beat, ncyc, first, run, resume, idx;
      for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
      mem[4] = 32'hDEAD_BEEF;
      mem[8] = 32'h55AA_1234;
      core_fn3 = 3'b010;
      dbg_fn3  = 3'b010;
      rst = 1'b1;
      set_core(1'b1, 1'b1, 32'h10, 32'h0);
      set_dbg(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

      // Reset: everything quiet even with a store requested.
      tick();
      @(negedge clk);
      chk("rst_outputs", {dm_wen, core_stall, dbg_gnt, core_rvalid, dbg_rvalid}, 0);
      chk("rst_dm_addr", dm_addr, 0);
      tick();
      rst = 1'b0;
      set_core(1'b0, 1'b0, 32'h0, 32'h0);

      // Core-only load of 0x10.
      tick();
      set_core(1'b1, 1'b0, 32'h10, 32'h0);
      @(negedge clk);
      chk("t1_stall", core_stall, 0);
      chk("t1_dm_addr", dm_addr, 32'h10);
      tick();
      set_core(1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      chk("t1_rvalid", core_rvalid, 1);
      chk("t1_rdata", core_rdata, 32'hDEAD_BEEF);
      chk("t1_dbg_rvalid", dbg_rvalid, 0);
      chk("t1_dbg_rdata", dbg_rdata, 0);
      tick();

      // Both requesting: core takes 8 slots, debug is forced on the 9th.
      set_core(1'b1, 1'b0, 32'h0, 32'h0);
      set_dbg(1'b1, 1'b0, 32'h40, 32'h0, 1'b0);
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         chk("t2_dbg_gnt", dbg_gnt, (i == 8));
         chk("t2_stall", core_stall, (i == 8));
         if (i == 0) chk("t2_mw0_tie_dbg", {m0_dbg_gnt, m0_core_stall}, 2'b11);
         tick();
      end
      @(negedge clk);
      chk("t2_wait_cleared", dut.u_wait.count, 0);
      chk("t2_core_back", core_stall, 0);
      chk("t2_dbg_rvalid", dbg_rvalid, 1);
      chk("t2_dbg_rdata", dbg_rdata, 32'h1000_0010);
      tick();
      set_core(1'b0, 1'b0, 32'h0, 32'h0);
      set_dbg(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      tick();

      // Locked burst of 20 writes against a continuously requesting core.
      // Cycles 0-7 core, 8-23 debug (16 locked), 24 core, then the wait
      // counter refills: 25-31 core, 32-35 debug finishes the burst.
      set_core(1'b1, 1'b0, 32'h0, 32'h0);
      beat = 0;
      ncyc = 0;
      for (int c = 0; c < 60 && beat < 20; c++) begin
         set_dbg(1'b1, 1'b1, 32'h80 + beat * 4, 32'hA000_0000 + beat, 1'b1);
         @(negedge clk);
         trace_d[c] = dbg_gnt;
         trace_s[c] = core_stall;
         if (dbg_gnt) beat++;
         ncyc = c + 1;
         tick();
      end
      set_core(1'b0, 1'b0, 32'h0, 32'h0);
      set_dbg(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      chk("t3_beats", beat, 20);
      first = -1;
      for (int c = 0; c < ncyc; c++) if (trace_d[c] && first < 0) first = c;
      run = 0;
      if (first >= 0) while (first + run < ncyc && trace_d[first + run]) run++;
      idx = (first < 0) ? 0 : first + run;
      resume = -1;
      for (int c = idx; c < ncyc; c++) if (trace_d[c] && resume < 0) resume = c;
      chk("t3_first_dbg", first, 8);
      chk("t3_locked_run", run, 16);
      chk("t3_core_slot", {trace_d[idx], trace_s[idx]}, 2'b00);
      chk("t3_resume", resume, 32);
      tick();
      chk("t3_mem_first", mem[32], 32'hA000_0000);
      chk("t3_mem_last", mem[51], 32'hA000_0013);

      // Debug read of 0x20, then core store to 0x20, then core load.
      set_dbg(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
      @(negedge clk);
      chk("t4_dbg_gnt", dbg_gnt, 1);
      tick();
      set_dbg(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      set_core(1'b1, 1'b1, 32'h20, 32'h1234_5678);
      @(negedge clk);
      chk("t4_dbg_rvalid", dbg_rvalid, 1);
      chk("t4_dbg_old", dbg_rdata, 32'h55AA_1234);
      chk("t4_store_wen", {dm_wen, core_stall}, 2'b10);
      tick();
      set_core(1'b1, 1'b0, 32'h20, 32'h0);
      @(negedge clk);
      chk("t4_no_wr_rvalid", core_rvalid, 0);
      tick();
      set_core(1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      chk("t4_core_rvalid", core_rvalid, 1);
      chk("t4_core_new", core_rdata, 32'h1234_5678);
      tick();

      // Reset pulsed right after a granted core read.
      set_core(1'b1, 1'b0, 32'h10, 32'h0);
      set_dbg(1'b1, 1'b0, 32'h40, 32'h0, 1'b0);
      tick();
      tick();
      @(negedge clk);
      chk("t5_pre_wait", dut.u_wait.count, 2);
      tick();
      rst = 1'b1;
      set_core(1'b0, 1'b0, 32'h0, 32'h0);
      set_dbg(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      @(negedge clk);
      chk("t5_rvalid_killed", {core_rvalid, dbg_rvalid}, 0);
      chk("t5_rdata_zero", core_rdata, 0);
      chk("t5_wait_zero", dut.u_wait.count, 0);
      chk("t5_lock_zero", dut.u_lock.count, 0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("t5_no_late_rvalid", core_rvalid, 0);
      tick();
      set_dbg(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
      @(negedge clk);
      chk("t5_gnt_after_rst", dbg_gnt, 1);
      tick();
      set_dbg(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      @(negedge clk);
      chk("t5_dbg_rdata", {dbg_rvalid, dbg_rdata}, {1'b1, 32'hDEAD_BEEF});
      tick();

      // Idle for 10 cycles.
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("t6_idle", {dm_wen, core_stall, dbg_gnt, core_rvalid, dbg_rvalid}, 0);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
